// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   DEF_WIDTH : default operand / quotient / remainder width
//   IDLE, CALC, FIX : FSM state encodings
//   DBZ_QUOT  : quotient reported on divide-by-zero (all ones)
package div_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [DEF_WIDTH-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   prem      : current partial remainder (WIDTH+1 bits)
//   dvd_msb   : next dividend bit shifted into the partial remainder
//   divisor   : divisor magnitude
//   prem_next : partial remainder after the trial subtract
//   qbit      : quotient bit produced by this iteration
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   prem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] divisor_ext;

    always_comb begin
        // The partial remainder is always below the divisor, so its top bit
        // is zero on entry and the shifted value still fits in WIDTH+1 bits.
        shifted     = (WIDTH+1)'({prem, dvd_msb});
        divisor_ext = {1'b0, divisor};
        // A non-negative trial difference is the same as shifted >= divisor.
        qbit        = (shifted >= divisor_ext);
        prem_next   = qbit ? (shifted - divisor_ext) : shifted;
    end

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit
// per clock.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : request, accepted only while busy is low
//   signed_op  : 1 = two's-complement operands, 0 = unsigned
//   dividend   : numerator
//   divisor    : denominator
//   busy       : operation in progress
//   res_valid  : one-cycle completion strobe
//   res        : {divide-by-zero flag, quotient}, held between completions
//   rem        : remainder, held between completions
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH:0]   res,
    output logic [WIDTH-1:0] rem
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             dbz;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .prem      (prem),
        .dvd_msb   (quo[WIDTH-1]),
        .divisor   (dvs),
        .prem_next (step_rem),
        .qbit      (step_q)
    );

    always_comb begin
        // -2^(WIDTH-1) negates to itself, which read as unsigned is its magnitude.
        dividend_abs = (signed_op && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
        divisor_abs  = (signed_op && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
        quot_fix     = neg_q ? (~quo + 1'b1) : quo;
        rem_fix      = neg_r ? (~prem[WIDTH-1:0] + 1'b1) : prem[WIDTH-1:0];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dbz       <= 1'b0;
            prem      <= '0;
            quo       <= '0;
            dvs       <= '0;
            res_valid <= 1'b0;
            res       <= '0;
            rem       <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // signed_op only matters through the two sign flags,
                        // so it is captured in them rather than kept separately.
                        neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= signed_op & dividend[WIDTH-1];
                        prem  <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        dvs   <= divisor_abs;
                        if (divisor == '0) begin
                            // The quotient register carries the raw dividend
                            // so it can be returned unmodified as the remainder.
                            dbz   <= 1'b1;
                            quo   <= dividend;
                            state <= FIX;
                        end else begin
                            dbz   <= 1'b0;
                            quo   <= dividend_abs;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Dividend bits leave the top of quo as quotient bits
                    // enter at the bottom.
                    prem <= step_rem;
                    quo  <= {quo[WIDTH-2:0], step_q};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    res_valid <= 1'b1;
                    state     <= IDLE;
                    if (dbz) begin
                        res <= {1'b1, WIDTH'(DBZ_QUOT)};
                        rem <= quo;
                    end else begin
                        res <= {1'b0, quot_fix};
                        rem <= rem_fix;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
